// File: rtl/seq_signed_divider.sv
// Multi-cycle signed divider: restoring shift-subtract, one quotient bit per clock.
// Operands are reduced to magnitudes on acceptance, divided unsigned, and the
// signs are re-applied in a single fix-up cycle before the done pulse.
module seq_signed_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, DIVIDE, FIXUP, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] dvd_raw;    // raw dividend, returned as remainder on divide-by-zero
    logic [WIDTH-1:0] dvs_mag;    // |divisor|
    logic [WIDTH-1:0] rem;        // partial remainder magnitude
    logic [WIDTH-1:0] qd;         // dividend magnitude shifting out, quotient bits shifting in
    logic [CW-1:0]    cnt;
    logic             dvd_neg;
    logic             dvs_neg;
    logic             dvs_zero;
    logic             ovf_case;

    logic [WIDTH-1:0] dvd_mag_in;
    logic [WIDTH-1:0] dvs_mag_in;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             borrow;
    logic [WIDTH-1:0] q_signed;
    logic [WIDTH-1:0] r_signed;

    // Operand magnitudes and one restoring step: the borrow of the WIDTH+1-bit
    // trial subtract decides the quotient bit. When no borrow occurs the true
    // difference is below |divisor| <= 2^(WIDTH-1), so its low WIDTH bits are exact.
    always_comb begin
        dvd_mag_in = dividend[WIDTH-1] ? (~dividend + 1'b1) : dividend;
        dvs_mag_in = divisor[WIDTH-1]  ? (~divisor + 1'b1)  : divisor;
        shifted    = {rem, qd[WIDTH-1]};
        borrow     = (shifted < {1'b0, dvs_mag});
        diff       = shifted[WIDTH-1:0] - dvs_mag;
        q_signed   = (dvd_neg ^ dvs_neg) ? (~qd + 1'b1) : qd;
        r_signed   = dvd_neg ? (~rem + 1'b1) : rem;
    end

    // Control FSM, datapath registers and registered result outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            dvd_raw     <= '0;
            dvs_mag     <= '0;
            rem         <= '0;
            qd          <= '0;
            cnt         <= '0;
            dvd_neg     <= 1'b0;
            dvs_neg     <= 1'b0;
            dvs_zero    <= 1'b0;
            ovf_case    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_raw  <= dividend;
                        dvs_mag  <= dvs_mag_in;
                        qd       <= dvd_mag_in;
                        rem      <= '0;
                        cnt      <= '0;
                        dvd_neg  <= dividend[WIDTH-1];
                        dvs_neg  <= divisor[WIDTH-1];
                        dvs_zero <= (divisor == '0);
                        ovf_case <= (dividend == MOST_NEG) && (divisor == '1);
                        busy     <= 1'b1;
                        state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    rem <= borrow ? shifted[WIDTH-1:0] : diff;
                    qd  <= {qd[WIDTH-2:0], ~borrow};
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIXUP;
                end
                FIXUP: begin
                    if (dvs_zero) begin
                        quotient  <= '1;
                        remainder <= dvd_raw;
                    end else if (ovf_case) begin
                        quotient  <= MOST_NEG;
                        remainder <= '0;
                    end else begin
                        quotient  <= q_signed;
                        remainder <= r_signed;
                    end
                    div_by_zero <= dvs_zero;
                    overflow    <= ovf_case && !dvs_zero;
                    done        <= 1'b1;
                    state       <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_signed_divider.sv
// Randomized self-checking bench for seq_signed_divider (WIDTH=8) against an
// integer-arithmetic reference model.
module tb_seq_signed_divider;

    localparam int W = 8;

    logic         clk;
    logic         reset;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    int n_cmp = 0;
    int n_bad = 0;

    seq_signed_divider #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: signed integer division truncating toward zero, with the
    // divide-by-zero and most-negative / -1 special cases.
    task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output logic ov);
        int ia, ib, iq, ir;
        ia = int'($signed(a));
        ib = int'($signed(b));
        dz = 1'b0;
        ov = 1'b0;
        if (ib == 0) begin
            iq = -1;
            ir = ia;
            dz = 1'b1;
        end else if (ia == -(2 ** (W - 1)) && ib == -1) begin
            iq = -(2 ** (W - 1));
            ir = 0;
            ov = 1'b1;
        end else begin
            iq = ia / ib;
            ir = ia % ib;
        end
        q = iq[W-1:0];
        r = ir[W-1:0];
    endtask

    // One operation: accept, optionally poke start with 9/2 mid-flight and in
    // the done cycle, measure latency, then check results and the return to idle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit disturb);
        logic [W-1:0] eq, er;
        logic         edz, eov;
        int           lat;
        bit           got;
        model(a, b, eq, er, edz, eov);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1;
        chk("busy_after_accept", 32'(busy), 32'd1);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        lat = 0;
        got = 0;
        while (!got && lat < 40) begin
            if (disturb && lat == 3) begin
                start    = 1'b1;
                dividend = 8'd9;
                divisor  = 8'd2;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
            if (done) got = 1;
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(W + 1));
        chk("quotient", 32'(quotient), 32'(eq));
        chk("remainder", 32'(remainder), 32'(er));
        chk("div_by_zero", 32'(div_by_zero), 32'(edz));
        chk("overflow", 32'(overflow), 32'(eov));
        if (disturb) begin
            start    = 1'b1;
            dividend = 8'd9;
            divisor  = 8'd2;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_cleared", 32'(busy), 32'd0);
        if (disturb) begin
            @(posedge clk);
            #1;
            chk("ignored_start_idle", 32'(busy), 32'd0);
            chk("held_quotient", 32'(quotient), 32'(eq));
            chk("held_remainder", 32'(remainder), 32'(er));
        end
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        reset    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Directed cases
        run_op(8'd100, 8'd7, 0);
        run_op(8'h9C, 8'd7, 0);      // -100 / 7
        run_op(8'd100, 8'hF9, 0);    // 100 / -7
        run_op(8'h80, 8'hFF, 0);     // overflow
        run_op(8'd25, 8'd0, 0);      // divide by zero
        run_op(8'h80, 8'd1, 0);
        run_op(8'h7F, 8'h80, 0);

        // Reset abandons an operation in DIVIDE
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_quotient", 32'(quotient), 32'd0);
        chk("midrst_remainder", 32'(remainder), 32'd0);
        chk("midrst_flags", 32'({div_by_zero, overflow}), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        begin
            bit saw_done;
            saw_done = 0;
            for (int i = 0; i < W + 4; i++) begin
                @(posedge clk);
                #1;
                if (done || busy) saw_done = 1;
            end
            chk("midrst_no_done", 32'(saw_done), 32'd0);
        end
        run_op(8'd50, 8'd5, 0);

        // start ignored while busy and in the done cycle
        run_op(8'd100, 8'd7, 1);
        run_op(8'd9, 8'd2, 0);

        // Randomized, biased toward the boundary operands
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                3: rb = 8'h80;
                default: ;
            endcase
            run_op(ra, rb, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
